program_loader: RTL and testbench
=================================

# program_loader

Writer side of the instruction ROM: receives a program image as a byte stream (typically from a UART receiver), packs it into 32-bit instruction words and writes them through the program memory's write port. The CPU is held in reset until a complete, checksum-verified image has been loaded. It sits between the serial front end and the program memory. The CPU fetches through word-aligned byte addresses, so this block generates byte addresses in the same form.

## Interface
- MEMORY_DEPTH, 32: number of instruction words in program memory; upper bound on the image length.
- DATA_WIDTH, 32: instruction/word width; must be 32, since 4 bytes are packed per word.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin a load.
- ByteIn  in  8  incoming byte.
- ByteValid  in  1  ByteIn holds a byte.
- ByteReady  out  1  block accepts a byte this cycle.
- MemWrite  out  1  write strobe to program memory.
- WriteAddress  out  DATA_WIDTH  byte address of the word being written; always a multiple of 4.
- WriteData  out  DATA_WIDTH  word being written.
- CpuHold  out  1  holds the CPU in reset while high.
- Done  out  1  image loaded and verified.
- Error  out  1  load aborted because of bad length or checksum.
- WordsLoaded  out  16  number of words written so far in the current load.

## Operation
- Stream format:
  - COUNT_HI, COUNT_LO: 16-bit word count N, big-endian.
  - 4N data bytes: each word is sent MSB first, so byte 0 goes to WriteData[31:24].
  - One checksum byte: XOR of all 4N data bytes.
- A byte is accepted on any rising edge where ByteValid && ByteReady are both high.
- States:
  - IDLE: ByteReady=0. Start goes to S_CNT_HI.
  - S_CNT_HI: accept a byte, store it as N[15:8], go to S_CNT_LO.
  - S_CNT_LO: accept a byte, store it as N[7:0].
    - If N > MEMORY_DEPTH, go to ERROR.
    - Else if N == 0, go to S_CHECK.
    - Else go to S_DATA.
  - S_DATA: accept bytes into a shift register and a byte counter (0..3), XORing each byte into the running checksum. The 4th byte goes to S_WRITE.
  - S_WRITE: ByteReady=0, MemWrite=1 for exactly 1 cycle, WriteAddress = WordsLoaded<<2, WriteData = packed word. WordsLoaded increments at the end of the cycle. If WordsLoaded+1 == N, go to S_CHECK; else go to S_DATA.
  - S_CHECK: accept one byte. If it equals the running checksum, go to DONE; else go to ERROR.
  - DONE: Done=1, CpuHold=0, ByteReady=0.
  - ERROR: Error=1, CpuHold=1, ByteReady=0.
- ByteReady=1 only in S_CNT_HI, S_CNT_LO, S_DATA and S_CHECK.
- Start is ignored in every state except IDLE, DONE and ERROR. In DONE or ERROR, Start restarts the load:
  - clears Done, Error, WordsLoaded and the checksum;
  - asserts CpuHold;
  - goes to S_CNT_HI.
- ByteValid without Start in IDLE/DONE/ERROR: the byte is not consumed and has no effect.
- Memory locations at or above index N keep their previous contents; the block never writes to them.

## Timing
- Reset values: ByteReady=0, MemWrite=0, WriteAddress=0, WriteData=0, CpuHold=1, Done=0, Error=0, WordsLoaded=0, state=IDLE. The shift register, count and checksum are all cleared.
- Reset asserted mid-load aborts immediately, with all outputs at their reset values. No partial MemWrite pulse may remain after reset asserts.
- The 4th data byte accepted at edge k gives MemWrite=1 in the cycle after edge k. The memory commits the word at edge k+1.
- Back-to-back bytes: sustained throughput is 4 bytes per 5 cycles, because of the one-cycle ready gap in S_WRITE.
- The final checksum byte accepted at edge k gives Done=1 and CpuHold=0 after edge k. A bad checksum or bad length gives Error=1 after the accepting edge.
- MemWrite, WriteAddress and WriteData are registered outputs and are glitch-free. WriteAddress and WriteData hold their last values outside S_WRITE.
- Start and ByteValid arriving in the same cycle in IDLE: only Start acts; the byte is not consumed (ByteReady=0).

## Test plan
- Reset, then Start, then 00 02, 20 08 00 05, 00 00 00 0C, checksum 0x21: expect MemWrite at address 0x0 with data 0x20080005, then at 0x4 with 0x0000000C. Then Done=1, CpuHold=0, WordsLoaded=2.
- Same image but checksum 0x22: expect both writes to occur, then Error=1, CpuHold=1, Done=0.
- Count 00 21 with MEMORY_DEPTH=32: expect Error=1 right after the COUNT_LO byte is accepted, and no MemWrite ever.
- Count 00 00 then checksum 00: expect Done=1 with no MemWrite. With checksum 05 instead: expect Error=1.
- Load 32 words with ByteValid held high continuously: expect the last write at 0x7C, a ByteReady gap of exactly 1 cycle per word, and Done=1.
- Assert reset in the middle of the 3rd word, then release and reload a 1-word image: expect all outputs at their reset values during reset, and the new load to start writing at address 0x0. Also confirm Start pulses sent during S_DATA are ignored.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: packs a byte-stream program image into 32-bit words,
// writes them to program memory and releases the CPU after checksum check.
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error,
    output logic [15:0]           WordsLoaded
);

    typedef enum logic [2:0] {
        IDLE, S_CNT_HI, S_CNT_LO, S_DATA,
        S_WRITE, S_CHECK, DONE, ERROR
    } state_t;

    state_t      state, state_nx;
    logic [15:0] count;
    logic [23:0] shift;
    logic [1:0]  bcnt;
    logic [7:0]  csum;
    logic        accept;
    logic        restart;
    logic [15:0] count_nx;

    assign accept   = ByteValid && ByteReady;
    assign restart  = Start && (state == IDLE || state == DONE || state == ERROR);
    assign count_nx = {count[15:8], ByteIn};

    assign ByteReady = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                       (state == S_DATA)   || (state == S_CHECK);
    assign Done      = (state == DONE);
    assign Error     = (state == ERROR);
    assign CpuHold   = (state != DONE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (Start) state_nx = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (accept) state_nx = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    if (count_nx > 16'(MEMORY_DEPTH)) state_nx = ERROR;
                    else if (count_nx == 16'd0)       state_nx = S_CHECK;
                    else                              state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && bcnt == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (WordsLoaded + 16'd1 == count) state_nx = S_CHECK;
                else                              state_nx = S_DATA;
            end
            S_CHECK: begin
                if (accept) state_nx = (ByteIn == csum) ? DONE : ERROR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: count, packing shift register, checksum and write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            shift        <= '0;
            bcnt         <= '0;
            csum         <= '0;
            WordsLoaded  <= '0;
            MemWrite     <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
        end else begin
            MemWrite <= 1'b0;
            if (restart) begin
                count       <= '0;
                shift       <= '0;
                bcnt        <= '0;
                csum        <= '0;
                WordsLoaded <= '0;
            end
            case (state)
                S_CNT_HI: if (accept) count[15:8] <= ByteIn;
                S_CNT_LO: if (accept) count[7:0]  <= ByteIn;
                S_DATA: begin
                    if (accept) begin
                        csum  <= csum ^ ByteIn;
                        bcnt  <= bcnt + 2'd1;
                        shift <= {shift[15:0], ByteIn};
                        if (bcnt == 2'd3) begin
                            MemWrite     <= 1'b1;
                            WriteData    <= DATA_WIDTH'({shift, ByteIn});
                            WriteAddress <= DATA_WIDTH'({WordsLoaded, 2'b00});
                        end
                    end
                end
                S_WRITE: WordsLoaded <= WordsLoaded + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads with a write scoreboard and
// status checks for program_loader.
module tb_program_loader;

    logic        clk = 0;
    logic        reset = 0;
    logic        Start = 0;
    logic [7:0]  ByteIn = 0;
    logic        ByteValid = 0;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CpuHold;
    logic        Done;
    logic        Error;
    logic [15:0] WordsLoaded;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] expq[$];
    bit measure = 0;
    int gaps = 0;

    program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .MemWrite(MemWrite), .WriteAddress(WriteAddress),
        .WriteData(WriteData), .CpuHold(CpuHold), .Done(Done),
        .Error(Error), .WordsLoaded(WordsLoaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is checked against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset && measure && !ByteReady) gaps++;
            if (reset && MemWrite) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %h data %h",
                             WriteAddress, WriteData);
                end else begin
                    logic [63:0] e;
                    e = expq.pop_front();
                    chk("write_addr", WriteAddress, e[63:32]);
                    chk("write_data", WriteData, e[31:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Start pulse with a junk byte offered at the same time
    task automatic do_start();
        @(negedge clk);
        Start = 1;
        ByteValid = 1;
        ByteIn = 8'hFF;
        @(posedge clk);
        #1;
        Start = 0;
        ByteValid = 0;
    endtask

    // Offer a byte until accepted; ByteValid is left high
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        ByteIn = b;
        ByteValid = 1;
        while (!ByteReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("byte_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        ByteValid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;

        #12;
        chk("rst_ready", 32'(ByteReady), 32'd0);
        chk("rst_hold", 32'(CpuHold), 32'd1);
        chk("rst_words", 32'(WordsLoaded), 32'd0);
        reset = 1;
        @(posedge clk);
        #1;

        // Good two-word image
        do_start();
        expq.push_back({32'h0, 32'h20080005});
        expq.push_back({32'h4, 32'h0000000C});
        send(8'h00); send(8'h02);
        send_word(32'h20080005);
        send_word(32'h0000000C);
        send(8'h21);
        idle();
        chk("t1_done", 32'(Done), 32'd1);
        chk("t1_hold", 32'(CpuHold), 32'd0);
        chk("t1_err", 32'(Error), 32'd0);
        chk("t1_words", 32'(WordsLoaded), 32'd2);

        // Same image, bad checksum
        do_start();
        chk("t2_restart_hold", 32'(CpuHold), 32'd1);
        chk("t2_restart_words", 32'(WordsLoaded), 32'd0);
        expq.push_back({32'h0, 32'h20080005});
        expq.push_back({32'h4, 32'h0000000C});
        send(8'h00); send(8'h02);
        send_word(32'h20080005);
        send_word(32'h0000000C);
        send(8'h22);
        idle();
        chk("t2_err", 32'(Error), 32'd1);
        chk("t2_hold", 32'(CpuHold), 32'd1);
        chk("t2_done", 32'(Done), 32'd0);

        // Length over MEMORY_DEPTH
        do_start();
        send(8'h00); send(8'h21);
        idle();
        chk("t3_err", 32'(Error), 32'd1);
        chk("t3_ready", 32'(ByteReady), 32'd0);
        chk("t3_words", 32'(WordsLoaded), 32'd0);

        // Zero-length image, good then bad checksum
        do_start();
        send(8'h00); send(8'h00); send(8'h00);
        idle();
        chk("t4_done", 32'(Done), 32'd1);
        do_start();
        send(8'h00); send(8'h00); send(8'h05);
        idle();
        chk("t4_err", 32'(Error), 32'd1);

        // Full 32-word image with ByteValid held high
        do_start();
        measure = 1;
        cs = 8'h00;
        send(8'h00); send(8'h20);
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'(i * 3), 8'hA5, 8'(~i)};
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            expq.push_back({32'(i * 4), w});
            send_word(w);
        end
        send(cs);
        measure = 0;
        idle();
        chk("t5_done", 32'(Done), 32'd1);
        chk("t5_words", 32'(WordsLoaded), 32'd32);
        chk("t5_gaps", 32'(gaps), 32'd32);

        // Reset in the middle of the 3rd word; Start ignored in S_DATA
        do_start();
        expq.push_back({32'h0, 32'h01020304});
        expq.push_back({32'h4, 32'h05060708});
        send(8'h00); send(8'h05);
        send_word(32'h01020304);
        send_word(32'h05060708);
        send(8'h11);
        @(negedge clk);
        ByteValid = 0;
        Start = 1;
        @(posedge clk);
        #1;
        Start = 0;
        chk("t6_start_ignored", 32'(ByteReady), 32'd1);
        chk("t6_words_mid", 32'(WordsLoaded), 32'd2);
        send(8'h22);
        @(negedge clk);
        ByteValid = 0;
        reset = 0;
        #1;
        chk("t6_rst_ready", 32'(ByteReady), 32'd0);
        chk("t6_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("t6_rst_addr", WriteAddress, 32'd0);
        chk("t6_rst_data", WriteData, 32'd0);
        chk("t6_rst_hold", 32'(CpuHold), 32'd1);
        chk("t6_rst_done", 32'(Done), 32'd0);
        chk("t6_rst_err", 32'(Error), 32'd0);
        chk("t6_rst_words", 32'(WordsLoaded), 32'd0);
        #20;
        reset = 1;
        do_start();
        expq.push_back({32'h0, 32'hDEADBEEF});
        send(8'h00); send(8'h01);
        send_word(32'hDEADBEEF);
        send(8'h22);
        idle();
        chk("t6_done", 32'(Done), 32'd1);
        chk("t6_words", 32'(WordsLoaded), 32'd1);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
